// File: rtl/mem_write_checker.sv
// Snoops CPU data-memory writes, compares result-address writes against a preloaded
// expected-value queue, and flags pass/fail on the completion write. Optional: CHK_TIMEOUT_EN.
module mem_write_checker #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 32,
  parameter int                 DEPTH      = 16,
  parameter int                 CNT_W      = 8,
  parameter logic [ADDR_W-1:0]  CHECK_ADDR = 32'h0200_0008,
  parameter logic [ADDR_W-1:0]  DONE_ADDR  = 32'h0200_000C,
  parameter logic [DATA_W-1:0]  DONE_VAL   = 32'd1,
  parameter bit                 STRICT     = 1'b1
`ifdef CHK_TIMEOUT_EN
  , parameter int               TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  chk_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_act,
  output logic              overflow
`ifdef CHK_TIMEOUT_EN
  , output logic            timeout
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_PASS = 2'd2, ST_FAIL = 2'd3} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   chk_q, chk_d, err_q, err_d;
  logic [DATA_W-1:0]  fexp_q, fexp_d, fact_q, fact_d, exp_v_s;
  logic               ovf_q, ovf_d, pass_q, pass_d, fail_q, fail_d, done_q, done_d;
  logic               rdy_q, rdy_d, push_s, err_new_s, chk_hit_s, done_hit_s;
`ifdef CHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);
  logic [TO_W-1:0] cyc_q, cyc_d;
  logic            to_q, to_d;
  assign timeout = to_q;
`endif

  assign chk_hit_s  = bus_we && (bus_addr == CHECK_ADDR);
  assign done_hit_s = bus_we && (bus_addr == DONE_ADDR) && (bus_wdata == DONE_VAL);

  // Next-state logic for the FSM, queue pointers, counters and result flags.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    chk_d     = chk_q;
    err_d     = err_q;
    fexp_d    = fexp_q;
    fact_d    = fact_q;
    ovf_d     = ovf_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    push_s    = 1'b0;
    err_new_s = 1'b0;
    exp_v_s   = '0;
`ifdef CHK_TIMEOUT_EN
    cyc_d     = cyc_q;
    to_d      = to_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (exp_valid && (count_q != OCC_FULL)) begin
          push_s   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + OCC_ONE;
        end else if (exp_valid) begin
          ovf_d = 1'b1;
        end else begin
          push_s = 1'b0;
        end
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (chk_hit_s && (count_q != OCC_ZERO)) begin
          chk_d     = sat_inc(chk_q);
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          count_d   = count_q - OCC_ONE;
          exp_v_s   = mem_q[rd_ptr_q];
          err_new_s = (bus_wdata != mem_q[rd_ptr_q]);
        end else if (chk_hit_s) begin
          // Underflow: a result write with nothing left to compare against.
          chk_d     = sat_inc(chk_q);
          err_new_s = 1'b1;
        end else begin
          err_new_s = 1'b0;
        end
        if (err_new_s) begin
          err_d = sat_inc(err_q);
          if (err_q == CNT_ZERO) begin
            fexp_d = exp_v_s;
            fact_d = bus_wdata;
          end else begin
            fexp_d = fexp_q;
          end
        end else begin
          err_d = err_q;
        end
`ifdef CHK_TIMEOUT_EN
        cyc_d = cyc_q + TO_ONE;
`endif
        if (done_hit_s) begin
          if ((err_d == CNT_ZERO) && (chk_d != CNT_ZERO) && (!STRICT || (count_d == OCC_ZERO))) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end
`ifdef CHK_TIMEOUT_EN
        end else if (cyc_d == TO_LIM) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          to_d    = 1'b1;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_LOAD;
    endcase
    done_d = pass_d | fail_d;
    rdy_d  = (state_d == ST_LOAD) && (count_d != OCC_FULL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      fexp_q   <= '0;
      fact_q   <= '0;
      ovf_q    <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b1;
`ifdef CHK_TIMEOUT_EN
      cyc_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      fexp_q   <= fexp_d;
      fact_q   <= fact_d;
      ovf_q    <= ovf_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
`ifdef CHK_TIMEOUT_EN
      cyc_q    <= cyc_d;
      to_q     <= to_d;
`endif
    end
  end

  // Queue storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= exp_data;
    end
  end

  assign exp_ready = rdy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign chk_count = chk_q;
  assign err_count = err_q;
  assign first_exp = fexp_q;
  assign first_act = fact_q;
  assign overflow  = ovf_q;

endmodule
